// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch port (IF) and the load/store data port (D). Accesses are serialised,
// and when both ports ask at once they take turns.
//
// Handshake: a requester raises req and holds it, with its address, write
// enable and write data stable, until it sees a one-cycle ack. Read data is
// valid in the ack cycle and is held until that port's next read completes.
// The arbiter samples requests only in IDLE, so a request that rises while a
// transaction is in flight waits its turn. If a request drops early, the
// latched transaction still completes and still produces an ack.
//
// Timing (cycle 0 = request sampled in IDLE):
//   1           ISSUE  mem_en pulse
//   2..1+LAT    WAIT   mem_rdata captured on the edge ending cycle 1+LAT
//   2+LAT       RESP   ack pulse
// All outputs are registered. They are computed from the next state, so each
// output lines up with the state named above.
module mem_port_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner_d
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The wait counter starts at LAT-1, so WAIT always lasts LAT cycles.
  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  state_t      state;
  state_t      next_state;
  logic [1:0]  wait_cnt;
  logic        lat_we;
  logic        any_req;
  logic        grant_d;
  logic        capture;
  logic        mem_en_n;
  logic        mem_we_n;
  logic        if_ack_n;
  logic        d_ack_n;
  logic        busy_n;

  // On a tie, grant the port that did not own the previous grant.
  assign any_req = if_req | d_req;
  assign grant_d = d_req & (~if_req | ~owner_d);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: IDLE -> ISSUE -> WAIT (LAT cycles) -> RESP -> IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (wait_cnt == 2'd0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: values that the output registers load at the next edge
  always_comb begin
    mem_en_n = (state == IDLE) && any_req;
    mem_we_n = mem_en_n & grant_d & d_we;
    capture  = (state == WAIT) && (wait_cnt == 2'd0);
    if_ack_n = capture & ~owner_d;
    d_ack_n  = capture & owner_d;
    busy_n   = (next_state != IDLE);
  end

  // Output registers, latched transaction fields, wait counter and read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_d   <= 1'b1;
      lat_we    <= 1'b0;
      wait_cnt  <= 2'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_en <= mem_en_n;
      mem_we <= mem_we_n;
      if_ack <= if_ack_n;
      d_ack  <= d_ack_n;
      busy   <= busy_n;
      if (mem_en_n) begin
        owner_d  <= grant_d;
        lat_we   <= grant_d & d_we;
        mem_addr <= grant_d ? d_addr : if_addr;
        if (grant_d) mem_wdata <= d_wdata;
      end
      if (state == ISSUE) begin
        wait_cnt <= LAT_INIT;
      end else if ((state == WAIT) && (wait_cnt != 2'd0)) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
      // A write leaves d_rdata untouched.
      if (capture) begin
        if (!owner_d)     if_rdata <= mem_rdata;
        else if (!lat_we) d_rdata  <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance a has MEM_LAT=1 and instance b has
// MEM_LAT=3. Each instance has its own memory model. Cycle numbers in the
// comments count from the cycle in which a request is raised (cycle 0).
module tb_mem_port_arbiter;

  localparam logic [31:0] POISON = 32'hBAD0BAD0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        if_req_a, if_ack_a, d_req_a, d_we_a, d_ack_a;
  logic        mem_en_a, mem_we_a, busy_a, owner_d_a;
  logic [5:0]  if_addr_a, d_addr_a, mem_addr_a;
  logic [31:0] if_rdata_a, d_wdata_a, d_rdata_a, mem_wdata_a, mem_rdata_a;
  logic        if_req_b, if_ack_b, d_req_b, d_we_b, d_ack_b;
  logic        mem_en_b, mem_we_b, busy_b, owner_d_b;
  logic [5:0]  if_addr_b, d_addr_b, mem_addr_b;
  logic [31:0] if_rdata_b, d_wdata_b, d_rdata_b, mem_wdata_b, mem_rdata_b;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          viol_cnt = 0;
  logic [32:0] exp_q[$];
  logic [3:0]  outstanding;
  logic        prev_en_a, prev_en_b;

  // Memory preload port. The memory models are the only writers of memory.
  logic        pl_en_a, pl_en_b;
  logic [5:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] rd1_b, rd2_b;

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_ack(if_ack_a), .if_rdata(if_rdata_a),
    .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_ack(d_ack_a), .d_rdata(d_rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .busy(busy_a), .owner_d(owner_d_a)
  );

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(32), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_ack(d_ack_b), .d_rdata(d_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b), .owner_d(owner_d_b)
  );

  // Memory a: data arrives 1 cycle after mem_en. Memory b: 3 cycles after.
  // A cycle with no access returns POISON.
  always @(posedge clk) begin
    if (pl_en_a) mem_a[pl_addr] <= pl_data;
    else if (mem_en_a && mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
    mem_rdata_a <= mem_en_a ? mem_a[mem_addr_a] : POISON;
  end

  always @(posedge clk) begin
    if (pl_en_b) mem_b[pl_addr] <= pl_data;
    else if (mem_en_b && mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    rd1_b       <= mem_en_b ? mem_b[mem_addr_b] : POISON;
    rd2_b       <= rd1_b;
    mem_rdata_b <= rd2_b;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Finishes the current cycle. Before advancing it checks the invariants and
  // tracks requests that drop before their ack. It then moves to 1 time unit
  // after the next rising edge.
  task automatic step();
    logic [3:0] reqs;
    logic [3:0] acks;
    if (rst) begin
      outstanding = '0;
      prev_en_a   = 1'b0;
      prev_en_b   = 1'b0;
    end else begin
      n_checks++;
      if (if_ack_a && d_ack_a) $display("FAIL ack_excl_a: both acks high at %0t, required at most one", $time);
      else n_pass++;
      n_checks++;
      if (if_ack_b && d_ack_b) $display("FAIL ack_excl_b: both acks high at %0t, required at most one", $time);
      else n_pass++;
      n_checks++;
      if (prev_en_a && mem_en_a) $display("FAIL mem_en_gap_a: mem_en high two cycles in a row at %0t, required gap", $time);
      else n_pass++;
      n_checks++;
      if (prev_en_b && mem_en_b) $display("FAIL mem_en_gap_b: mem_en high two cycles in a row at %0t, required gap", $time);
      else n_pass++;
      reqs = {d_req_b, if_req_b, d_req_a, if_req_a};
      acks = {d_ack_b, if_ack_b, d_ack_a, if_ack_a};
      for (int i = 0; i < 4; i++) begin
        if (acks[i]) begin
          outstanding[i] = 1'b0;
        end else if (outstanding[i] && !reqs[i]) begin
          viol_cnt++;
          $display("note: protocol violation, request %0d dropped before its ack at %0t", i, $time);
          outstanding[i] = 1'b0;
        end else if (reqs[i]) begin
          outstanding[i] = 1'b1;
        end
      end
      prev_en_a = mem_en_a;
      prev_en_b = mem_en_b;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req_a = 0; if_addr_a = '0; d_req_a = 0; d_we_a = 0; d_addr_a = '0; d_wdata_a = '0;
    if_req_b = 0; if_addr_b = '0; d_req_b = 0; d_we_b = 0; d_addr_b = '0; d_wdata_b = '0;
    pl_en_a = 0; pl_en_b = 0; pl_addr = '0; pl_data = '0;
    step();
    step();
    pl_en_a = 1; pl_addr = 6'd5;  pl_data = 32'h00A00093; step();
    pl_addr = 6'd12; pl_data = 32'h0BADC0DE; step();
    pl_en_a = 0; pl_en_b = 1;
    pl_addr = 6'd20; pl_data = 32'h12345678; step();
    pl_addr = 6'd7;  pl_data = 32'hCAFEF00D; step();
    pl_en_b = 0;
    n_checks++;
    if ({busy_a, mem_en_a, mem_we_a, if_ack_a, d_ack_a, owner_d_a} !== 6'b000001)
      $display("FAIL reset_ctrl_a: got %b required 000001", {busy_a, mem_en_a, mem_we_a, if_ack_a, d_ack_a, owner_d_a});
    else n_pass++;
    n_checks++;
    if ({mem_addr_a, mem_wdata_a, if_rdata_a, d_rdata_a} !== 102'd0)
      $display("FAIL reset_data_a: got %h %h %h %h required all 0", mem_addr_a, mem_wdata_a, if_rdata_a, d_rdata_a);
    else n_pass++;
    n_checks++;
    if ({busy_b, mem_en_b, mem_we_b, if_ack_b, d_ack_b, owner_d_b} !== 6'b000001)
      $display("FAIL reset_ctrl_b: got %b required 000001", {busy_b, mem_en_b, mem_we_b, if_ack_b, d_ack_b, owner_d_b});
    else n_pass++;
    n_checks++;
    if ({mem_addr_b, mem_wdata_b, if_rdata_b, d_rdata_b} !== 102'd0)
      $display("FAIL reset_data_b: got %h %h %h %h required all 0", mem_addr_b, mem_wdata_b, if_rdata_b, d_rdata_b);
    else n_pass++;
    rst = 1'b0;
    step();
    n_checks++;
    if ({busy_a, mem_en_a, busy_b, mem_en_b} !== 4'b0000)
      $display("FAIL idle_no_req: got %b required 0000", {busy_a, mem_en_a, busy_b, mem_en_b});
    else n_pass++;
  endtask

  // Single IF read on instance a, checked cycle by cycle.
  task automatic test_if_read();
    logic [32:0] got;
    if_addr_a = 6'd5; if_req_a = 1'b1;            // cycle 0
    exp_q.push_back({1'b0, 32'h00A00093});
    step();                                        // cycle 1
    n_checks++;
    if ({mem_en_a, mem_we_a, busy_a, mem_addr_a} !== {3'b101, 6'd5})
      $display("FAIL if_issue: got en/we/busy %b addr %0d required 101 addr 5", {mem_en_a, mem_we_a, busy_a}, mem_addr_a);
    else n_pass++;
    step();                                        // cycle 2
    n_checks++;
    if ({mem_en_a, if_ack_a, busy_a} !== 3'b001)
      $display("FAIL if_wait: got en/ack/busy %b required 001", {mem_en_a, if_ack_a, busy_a});
    else n_pass++;
    step();                                        // cycle 3
    n_checks++;
    if ({if_ack_a, d_ack_a, busy_a} !== 3'b101)
      $display("FAIL if_resp: got if_ack/d_ack/busy %b required 101", {if_ack_a, d_ack_a, busy_a});
    else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL if_rdata: ack with empty expected queue, got %h", if_rdata_a);
    end else begin
      got = exp_q.pop_front();
      if ({1'b0, if_rdata_a} !== got) $display("FAIL if_rdata: got %h required %h", if_rdata_a, got[31:0]);
      else n_pass++;
    end
    if_req_a = 1'b0;
    step();                                        // cycle 4
    n_checks++;
    if ({if_ack_a, busy_a} !== 2'b00)
      $display("FAIL if_done: got ack/busy %b required 00", {if_ack_a, busy_a});
    else n_pass++;
  endtask

  // D write to address 10 followed by a D read of the same address (instance a).
  task automatic test_d_write_read();
    int          ack_cyc;
    int          en_cnt;
    logic        we_ok;
    logic        if_seen;
    logic [31:0] rd_at_ack;
    logic [32:0] got;
    ack_cyc = -1; en_cnt = 0; we_ok = 1'b0; if_seen = 1'b0; rd_at_ack = POISON;
    d_we_a = 1'b1; d_addr_a = 6'd10; d_wdata_a = 32'hDEADBEEF; d_req_a = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (mem_en_a) begin
        en_cnt++;
        we_ok = mem_we_a && (mem_addr_a == 6'd10) && (mem_wdata_a == 32'hDEADBEEF);
      end
      if (if_ack_a) if_seen = 1'b1;
      if (d_ack_a && ack_cyc < 0) begin
        ack_cyc = c; rd_at_ack = d_rdata_a; d_req_a = 1'b0;
      end
    end
    n_checks++;
    if (ack_cyc !== 3) $display("FAIL wr_ack_cycle: got %0d required 3", ack_cyc); else n_pass++;
    n_checks++;
    if ({en_cnt == 1, we_ok} !== 2'b11) $display("FAIL wr_issue: got en_cnt %0d we/addr/data ok %0b required 1 and 1", en_cnt, we_ok);
    else n_pass++;
    n_checks++;
    if (rd_at_ack !== 32'h0) $display("FAIL wr_rdata_kept: got %h required 00000000", rd_at_ack); else n_pass++;

    ack_cyc = -1; en_cnt = 0; we_ok = 1'b1;
    d_we_a = 1'b0; d_req_a = 1'b1;                 // cycle 0 of the read
    exp_q.push_back({1'b1, 32'hDEADBEEF});
    for (int c = 1; c <= 8; c++) begin
      step();
      if (mem_en_a && mem_we_a) we_ok = 1'b0;
      if (if_ack_a) if_seen = 1'b1;
      if (d_ack_a && ack_cyc < 0) begin
        ack_cyc = c; d_req_a = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rd_rdata: ack with empty expected queue, got %h", d_rdata_a);
        end else begin
          got = exp_q.pop_front();
          if ({1'b1, d_rdata_a} !== got) $display("FAIL rd_rdata: got %h required %h", d_rdata_a, got[31:0]);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (ack_cyc !== 3) $display("FAIL rd_ack_cycle: got %0d required 3", ack_cyc); else n_pass++;
    n_checks++;
    if ({we_ok, if_seen} !== 2'b10) $display("FAIL rd_side: got read_no_we %0b if_ack_seen %0b required 1 0", we_ok, if_seen);
    else n_pass++;
  endtask

  // Both ports requesting continuously from reset: IF, D, IF, D every 4 cycles.
  task automatic test_dual_rr();
    int          n_ack;
    int          n_if;
    int          n_d;
    logic [32:0] got;
    n_ack = 0; n_if = 0; n_d = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;                                    // cycle 0
    if_addr_a = 6'd5; if_req_a = 1'b1;
    d_addr_a = 6'd10; d_we_a = 1'b0; d_req_a = 1'b1;
    exp_q.push_back({1'b0, 32'h00A00093});
    exp_q.push_back({1'b1, 32'hDEADBEEF});
    exp_q.push_back({1'b0, 32'h00A00093});
    exp_q.push_back({1'b1, 32'hDEADBEEF});
    for (int c = 1; c <= 18; c++) begin
      step();
      if (if_ack_a || d_ack_a) begin
        n_checks++;
        if (c !== 3 + 4 * n_ack) $display("FAIL rr_ack_cycle: ack %0d got cycle %0d required %0d", n_ack, c, 3 + 4 * n_ack);
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rr_order: extra ack at cycle %0d, required none", c);
        end else begin
          got = exp_q.pop_front();
          if ({d_ack_a, d_ack_a ? d_rdata_a : if_rdata_a} !== got)
            $display("FAIL rr_order: got port %0b data %h required port %0b data %h", d_ack_a,
                     d_ack_a ? d_rdata_a : if_rdata_a, got[32], got[31:0]);
          else n_pass++;
        end
        n_ack++;
        if (if_ack_a) begin n_if++; if (n_if == 2) if_req_a = 1'b0; end
        if (d_ack_a)  begin n_d++;  if (n_d == 2)  d_req_a  = 1'b0; end
      end
    end
    if_req_a = 1'b0; d_req_a = 1'b0;
    n_checks++;
    if ((n_ack !== 4) || (exp_q.size() != 0)) $display("FAIL rr_count: got %0d acks required 4", n_ack);
    else n_pass++;
    exp_q.delete();
  endtask

  // MEM_LAT=3 D read on instance b: one mem_en, capture at end of cycle 4, ack at 5.
  task automatic test_d_read_lat3();
    int          en_first;
    int          en_cnt;
    int          ack_cyc;
    logic [31:0] rd_c4;
    logic [32:0] got;
    en_first = -1; en_cnt = 0; ack_cyc = -1; rd_c4 = POISON;
    d_addr_b = 6'd20; d_we_b = 1'b0; d_req_b = 1'b1;
    exp_q.push_back({1'b1, 32'h12345678});
    for (int c = 1; c <= 9; c++) begin
      step();
      if (mem_en_b) begin en_cnt++; if (en_first < 0) en_first = c; end
      if (c == 4) rd_c4 = d_rdata_b;
      if (d_ack_b && ack_cyc < 0) begin
        ack_cyc = c; d_req_b = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL lat3_rdata: ack with empty expected queue, got %h", d_rdata_b);
        end else begin
          got = exp_q.pop_front();
          if ({1'b1, d_rdata_b} !== got) $display("FAIL lat3_rdata: got %h required %h", d_rdata_b, got[31:0]);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if ({en_first, en_cnt} !== {32'sd1, 32'sd1}) $display("FAIL lat3_mem_en: got first %0d count %0d required 1 1", en_first, en_cnt);
    else n_pass++;
    n_checks++;
    if (rd_c4 !== 32'h0) $display("FAIL lat3_capture_time: d_rdata at cycle 4 got %h required 00000000", rd_c4); else n_pass++;
    n_checks++;
    if (ack_cyc !== 5) $display("FAIL lat3_ack_cycle: got %0d required 5", ack_cyc); else n_pass++;
  endtask

  // Reset during WAIT of an IF read on instance b. The held request is sampled
  // again in the cycle after reset and acked 5 cycles later.
  task automatic test_reset_mid();
    int          ack_cyc;
    logic [32:0] got;
    ack_cyc = -1;
    if_addr_b = 6'd7; if_req_b = 1'b1;            // cycle 0
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    step();                                        // cycle 1
    step();                                        // cycle 2 (WAIT)
    n_checks++;
    if ({busy_b, if_ack_b} !== 2'b10) $display("FAIL rst_mid_wait: got busy/ack %b required 10", {busy_b, if_ack_b});
    else n_pass++;
    rst = 1'b1;
    step();                                        // cycle 3
    rst = 1'b0;
    n_checks++;
    if ({busy_b, mem_en_b, mem_we_b, if_ack_b, d_ack_b, owner_d_b} !== 6'b000001)
      $display("FAIL rst_mid_ctrl: got %b required 000001", {busy_b, mem_en_b, mem_we_b, if_ack_b, d_ack_b, owner_d_b});
    else n_pass++;
    n_checks++;
    if ({mem_addr_b, mem_wdata_b, if_rdata_b, d_rdata_b} !== 102'd0)
      $display("FAIL rst_mid_data: got %h %h %h %h required all 0", mem_addr_b, mem_wdata_b, if_rdata_b, d_rdata_b);
    else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (if_ack_b && ack_cyc < 0) begin
        ack_cyc = k; if_req_b = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rst_mid_rdata: ack with empty expected queue, got %h", if_rdata_b);
        end else begin
          got = exp_q.pop_front();
          if ({1'b0, if_rdata_b} !== got) $display("FAIL rst_mid_rdata: got %h required %h", if_rdata_b, got[31:0]);
          else n_pass++;
        end
      end
    end
    if_req_b = 1'b0;
    n_checks++;
    if (ack_cyc !== 5) $display("FAIL rst_mid_ack: got %0d cycles after resample required 5", ack_cyc); else n_pass++;
  endtask

  // d_req dropped in cycle 2 of a D read on instance a. The read still completes,
  // and an IF request raised meanwhile is sampled in cycle 4.
  task automatic test_req_drop();
    int          d_ack_cyc;
    int          if_ack_cyc;
    int          if_en_cyc;
    int          viol0;
    logic [5:0]  if_en_addr;
    logic [32:0] got;
    d_ack_cyc = -1; if_ack_cyc = -1; if_en_cyc = -1; if_en_addr = '0; viol0 = viol_cnt;
    d_addr_a = 6'd12; d_we_a = 1'b0; d_req_a = 1'b1;   // cycle 0
    exp_q.push_back({1'b1, 32'h0BADC0DE});
    step();
    step();                                             // cycle 2
    d_req_a = 1'b0;
    if_addr_a = 6'd5; if_req_a = 1'b1;
    exp_q.push_back({1'b0, 32'h00A00093});
    for (int c = 3; c <= 12; c++) begin
      step();
      if (mem_en_a && c >= 4 && if_en_cyc < 0) begin if_en_cyc = c; if_en_addr = mem_addr_a; end
      if ((if_ack_a || d_ack_a) && exp_q.size() != 0) begin
        got = exp_q.pop_front();
        n_checks++;
        if ({d_ack_a, d_ack_a ? d_rdata_a : if_rdata_a} !== got)
          $display("FAIL drop_rdata: got port %0b data %h required port %0b data %h", d_ack_a,
                   d_ack_a ? d_rdata_a : if_rdata_a, got[32], got[31:0]);
        else n_pass++;
      end
      if (d_ack_a && d_ack_cyc < 0) d_ack_cyc = c;
      if (if_ack_a && if_ack_cyc < 0) begin if_ack_cyc = c; if_req_a = 1'b0; end
    end
    if_req_a = 1'b0;
    n_checks++;
    if (d_ack_cyc !== 3) $display("FAIL drop_d_ack: got %0d required 3", d_ack_cyc); else n_pass++;
    n_checks++;
    if ({if_en_cyc, if_en_addr} !== {32'sd5, 6'd5}) $display("FAIL drop_if_issue: got cycle %0d addr %0d required 5 5", if_en_cyc, if_en_addr);
    else n_pass++;
    n_checks++;
    if (if_ack_cyc !== 7) $display("FAIL drop_if_ack: got %0d required 7", if_ack_cyc); else n_pass++;
    n_checks++;
    if (viol_cnt - viol0 !== 1) $display("FAIL drop_flag: got %0d violations required 1", viol_cnt - viol0); else n_pass++;
  endtask

  initial begin
    outstanding = '0;
    prev_en_a = 1'b0;
    prev_en_b = 1'b0;
    test_reset();
    test_if_read();
    test_d_write_read();
    test_dual_rr();
    test_d_read_lat3();
    test_req_drop();
    test_reset_mid();
    step();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d pending required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
